argmax_classifier: RTL and testbench
====================================

// Module: argmax_classifier
// PURPOSE
//  Output stage placed directly downstream of the final dense layer. Snapshots the layer's
//  signed output vector on its ready pulse, scans it one element per cycle and reports the
//  index of the largest value as the predicted class. Single clock, one result per scan.
// PARAMETERS
//  DATA_WIDTH  32  width of each signed input element (two's complement)
//  NUM_INPUTS  10  number of classes / vector elements; must be >= 1
//  INDEX_WIDTH $clog2(NUM_INPUTS) (min 1)  width of class_index
// PORTS
//  clock          in   1                       rising-edge clock
//  reset          in   1                       asynchronous, active-low reset
//  inputs_ready   in   1                       one-cycle pulse: inputs valid this cycle
//  inputs         in   DATA_WIDTH x NUM_INPUTS unpacked signed vector from dense layer
//  class_index    out  INDEX_WIDTH             index of maximum element
//  class_valid    out  1                       one-cycle pulse: class_index valid
//  busy           out  1                       high while scanning (state SCAN)
//  overrun        out  1                       sticky: inputs_ready arrived while busy
//  max_value      out  DATA_WIDTH              [ARGMAX_CONFIDENCE_EN only] winning value
//  margin         out  DATA_WIDTH+1            [ARGMAX_CONFIDENCE_EN only] max - runner-up
// BEHAVIOUR
//  - reset low (async): state=IDLE; class_index=0, class_valid=0, busy=0, overrun=0,
//    max_value=0, margin=0; snapshot contents don't-care.
//  - States IDLE, SCAN, DONE. Accept = inputs_ready high while state is IDLE or DONE.
//  - Accept edge: copy all inputs to snapshot, best=inputs[0], best_idx=0, i=1;
//    next state SCAN (DONE directly if NUM_INPUTS==1).
//  - SCAN, each edge: if snapshot[i] > best (signed, strict) then best=snapshot[i],
//    best_idx=i; i++. Edge with i==NUM_INPUTS-1 -> DONE.
//  - DONE (one cycle): class_valid=1, class_index=best_idx; then IDLE, or SCAN if an
//    accept occurs in that same cycle (back-to-back, no bubble).
//  - Latency: class_valid rises NUM_INPUTS edges after the accept edge; throughput one
//    vector per NUM_INPUTS cycles. class_index holds its value until the next DONE.
//  - Ties: lowest index wins (strict >). Most-negative value handled by signed compare.
//  - inputs_ready during SCAN: ignored, snapshot untouched, overrun set (sticky to reset).
//  - inputs may change freely after the accept edge; only the snapshot is used.
//  - Reset asserted mid-scan: scan abandoned, no class_valid produced.
// CONFIGURATION
//  ARGMAX_CONFIDENCE_EN defined: also track runner-up (init to most-negative value,
//  updated when displaced best or snapshot[i] > runner-up); in DONE drive max_value=best,
//  margin=best-runner_up computed sign-extended to DATA_WIDTH+1 (no overflow); for
//  NUM_INPUTS==1 margin=0. Ports max_value/margin exist only when defined.
//  Undefined: no runner-up register, no max_value/margin ports.
// STRUCTURE
//  - Shared package nn_pkg: state enum argmax_state_t {IDLE, SCAN, DONE}, alongside the
//    existing activation_type typedef; helper function index_width(n) for INDEX_WIDTH.
//  - No sub-module: snapshot register, scan counter and comparator inline in one FSM.
// TESTING
//  - NUM_INPUTS=10, inputs={3,-1,7,2,0,0,0,0,0,5}, pulse -> class_valid 10 edges later, index 2.
//  - All elements equal (-4) -> index 0; with EN, max_value=-4, margin=0.
//  - Max at last element (others -100, [9]=1); element 0 = most-negative -> index 9.
//  - Second pulse during SCAN -> ignored, result from first vector, overrun=1 until reset.
//  - Pulse in DONE cycle with new vector -> two class_valid pulses exactly 10 cycles apart.
//  - Reset low at scan cycle 4 -> outputs zero immediately, no class_valid; next vector OK.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared neural-network pipeline package.
//   argmax_state_t  : scan FSM states used by argmax_classifier
//   activation_type : activation selector used by the dense layers
//   index_width()   : width of an index into an n-element vector (minimum 1)
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

    typedef enum logic [1:0] {
        ACT_NONE    = 2'd0,
        ACT_RELU    = 2'd1,
        ACT_SIGMOID = 2'd2,
        ACT_TANH    = 2'd3
    } activation_type;

    // A one-element vector still needs a 1-bit index port.
    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/argmax_classifier.sv
// argmax_classifier: output stage after the final dense layer. Snapshots the
// signed output vector on inputs_ready, scans one element per clock and
// reports the index of the largest element (lowest index wins ties).
//
// Ports
//   clock        : rising-edge clock
//   reset        : asynchronous, active-low reset
//   inputs_ready : one-cycle pulse, inputs valid this cycle
//   inputs       : NUM_INPUTS signed DATA_WIDTH-bit elements
//   class_index  : index of the maximum element, held until the next result
//   class_valid  : one-cycle pulse, class_index (and confidence outputs) valid
//   busy         : high while scanning
//   overrun      : sticky, inputs_ready seen while busy (cleared by reset only)
//   max_value    : winning value          (ARGMAX_CONFIDENCE_EN only)
//   margin       : winner minus runner-up (ARGMAX_CONFIDENCE_EN only)
//   state_dbg    : current FSM state, for observation only
//
// Handshake: there is no back-pressure. A vector is accepted on any clock edge
// where inputs_ready is high and the FSM is in IDLE or DONE; a pulse while
// busy is dropped and flagged in overrun. class_valid pulses for exactly one
// cycle, NUM_INPUTS edges after the accepting edge, and is never stalled.
//
// Configuration macro: ARGMAX_CONFIDENCE_EN adds runner-up tracking and the
// max_value / margin outputs.
module argmax_classifier
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_INPUTS  = 10,
    parameter int INDEX_WIDTH = index_width(NUM_INPUTS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         inputs_ready,
    input  logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
    output logic [INDEX_WIDTH-1:0]       class_index,
    output logic                         class_valid,
    output logic                         busy,
    output logic                         overrun,
`ifdef ARGMAX_CONFIDENCE_EN
    output logic signed [DATA_WIDTH-1:0] max_value,
    output logic signed [DATA_WIDTH:0]   margin,
`endif
    output argmax_state_t                state_dbg
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);
    localparam logic [INDEX_WIDTH-1:0] ONE_IDX  = INDEX_WIDTH'(1);

    argmax_state_t state_q, state_d;
    logic signed [DATA_WIDTH-1:0] snap_q [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0] snap_d [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0] best_q, best_d;
    logic [INDEX_WIDTH-1:0]       best_idx_q, best_idx_d;
    logic [INDEX_WIDTH-1:0]       idx_q, idx_d;
    logic [INDEX_WIDTH-1:0]       class_index_q, class_index_d;
    logic                         class_valid_q, class_valid_d;
    logic                         overrun_q, overrun_d;
    logic                         accept;
    logic signed [DATA_WIDTH-1:0] cur;
`ifdef ARGMAX_CONFIDENCE_EN
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic signed [DATA_WIDTH-1:0] runner_q, runner_d;
    logic signed [DATA_WIDTH-1:0] max_value_q, max_value_d;
    logic signed [DATA_WIDTH:0]   margin_q, margin_d;
`endif

    // DONE is the only non-busy state besides IDLE, so a vector may arrive in
    // the result cycle and start the next scan without a bubble.
    assign accept = inputs_ready && (state_q != SCAN);
    assign cur    = snap_q[idx_q];

    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;
        idx_d         = idx_q;
        class_index_d = class_index_q;
        // Registered on the edge leaving DONE, giving NUM_INPUTS edges of latency.
        class_valid_d = (state_q == DONE);
        overrun_d     = overrun_q | (inputs_ready && (state_q == SCAN));
`ifdef ARGMAX_CONFIDENCE_EN
        runner_d      = runner_q;
        max_value_d   = max_value_q;
        margin_d      = margin_q;
`endif

        if (state_q == DONE) begin
            class_index_d = best_idx_q;
`ifdef ARGMAX_CONFIDENCE_EN
            max_value_d   = best_q;
            // Sign-extend both operands so the difference cannot overflow.
            margin_d      = (NUM_INPUTS == 1) ? '0 :
                            ({best_q[DATA_WIDTH-1], best_q} - {runner_q[DATA_WIDTH-1], runner_q});
`endif
        end

        case (state_q)
            SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if (cur > best_q) begin
                    best_d     = cur;
                    best_idx_d = idx_q;
                end
`ifdef ARGMAX_CONFIDENCE_EN
                if (cur > best_q) begin
                    runner_d = best_q;
                end else if (cur > runner_q) begin
                    runner_d = cur;
                end
`endif
                idx_d = idx_q + ONE_IDX;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            snap_d     = inputs;
            best_d     = inputs[0];
            best_idx_d = '0;
            idx_d      = ONE_IDX;
            state_d    = (NUM_INPUTS == 1) ? DONE : SCAN;
`ifdef ARGMAX_CONFIDENCE_EN
            runner_d   = MOST_NEG;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            best_q        <= '0;
            best_idx_q    <= '0;
            idx_q         <= '0;
            class_index_q <= '0;
            class_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef ARGMAX_CONFIDENCE_EN
            runner_q      <= '0;
            max_value_q   <= '0;
            margin_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            idx_q         <= idx_d;
            class_index_q <= class_index_d;
            class_valid_q <= class_valid_d;
            overrun_q     <= overrun_d;
`ifdef ARGMAX_CONFIDENCE_EN
            runner_q      <= runner_d;
            max_value_q   <= max_value_d;
            margin_q      <= margin_d;
`endif
        end
    end

    // Snapshot contents are only meaningful after an accept, so no reset.
    always_ff @(posedge clock) begin
        snap_q <= snap_d;
    end

    assign class_index = class_index_q;
    assign class_valid = class_valid_q;
    assign busy        = (state_q == SCAN);
    assign overrun     = overrun_q;
    assign state_dbg   = state_q;
`ifdef ARGMAX_CONFIDENCE_EN
    assign max_value   = max_value_q;
    assign margin      = margin_q;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier (DATA_WIDTH=32, NUM_INPUTS=10).
module tb_argmax_classifier;
    import nn_pkg::*;

    localparam int DW = 32;
    localparam int N  = 10;
    localparam int IW = 4;

    typedef logic signed [DW-1:0] vec_t [N];

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic inputs_ready = 1'b0;
    vec_t inputs;
    logic [IW-1:0] class_index;
    logic class_valid;
    logic busy;
    logic overrun;
    argmax_state_t state_dbg;
`ifdef ARGMAX_CONFIDENCE_EN
    logic signed [DW-1:0] max_value;
    logic signed [DW:0]   margin;
`endif

    int checks = 0;
    int errors = 0;

    vec_t vec_a, vec_b, vec_c, vec_d;

    argmax_classifier #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .inputs_ready (inputs_ready),
        .inputs       (inputs),
        .class_index  (class_index),
        .class_valid  (class_valid),
        .busy         (busy),
        .overrun      (overrun),
`ifdef ARGMAX_CONFIDENCE_EN
        .max_value    (max_value),
        .margin       (margin),
`endif
        .state_dbg    (state_dbg)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input vec_t v);
        inputs = v;
        inputs_ready = 1'b1;
        step();
        inputs_ready = 1'b0;
    endtask

    // Counts edges from 'start' until class_valid is seen, then checks result.
    task automatic wait_valid(input string tag, input int start, input int exp_edges,
                              input int exp_idx, input int exp_max, input int exp_margin);
        int n;
        bit found;
        n = start;
        found = 1'b0;
        while (!found && n < start + 40) begin
            step();
            n++;
            if (class_valid) found = 1'b1;
        end
        check({tag, "_latency"}, found ? n : -1, exp_edges);
        check({tag, "_index"}, class_index, exp_idx);
`ifdef ARGMAX_CONFIDENCE_EN
        check({tag, "_max_value"}, max_value, exp_max);
        check({tag, "_margin"}, margin, exp_margin);
`else
        if (exp_max != exp_margin) begin end
`endif
    endtask

    initial begin
        int n;
        int valid_count;

        vec_a = '{3, -1, 7, 2, 0, 0, 0, 0, 0, 5};
        vec_b = '{-4, -4, -4, -4, -4, -4, -4, -4, -4, -4};
        vec_c = '{32'sh8000_0000, -100, -100, -100, -100, -100, -100, -100, -100, 1};
        vec_d = '{0, 0, 0, 0, 0, 0, 11, 0, 11, -3};
        inputs = '{default: '0};

        // Reset state
        step();
        step();
        check("rst_index", class_index, 0);
        check("rst_valid", class_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", state_dbg, IDLE);
        reset = 1'b1;
        step();

        // Basic vector: max 7 at index 2
        pulse(vec_a);
        check("a_busy", busy, 1);
        check("a_state", state_dbg, SCAN);
        wait_valid("a", 0, 10, 2, 7, 2);
        step();
        check("a_valid_one_cycle", class_valid, 0);
        check("a_index_hold", class_index, 2);
        check("a_idle", state_dbg, IDLE);

        // All equal: lowest index wins
        pulse(vec_b);
        wait_valid("b", 0, 10, 0, -4, 0);

        // Most-negative at 0, max at last element
        pulse(vec_c);
        wait_valid("c", 0, 10, 9, 1, 101);

        // Pulse during SCAN is ignored and flags overrun
        pulse(vec_a);
        step();
        step();
        inputs = vec_b;
        inputs_ready = 1'b1;
        step();
        inputs_ready = 1'b0;
        check("ovr_flag", overrun, 1);
        check("ovr_busy", busy, 1);
        inputs = vec_c;
        wait_valid("ovr", 3, 10, 2, 7, 2);
        step();
        check("ovr_sticky", overrun, 1);
        check("ovr_after_valid", class_valid, 0);

        // Reset clears overrun
        reset = 1'b0;
        #1;
        check("ovr_reset_clear", overrun, 0);
        step();
        reset = 1'b1;
        step();

        // Back-to-back: accept in the DONE cycle
        pulse(vec_a);
        n = 0;
        while (state_dbg != DONE && n < 30) begin
            step();
            n++;
        end
        check("b2b_done_edges", n, 9);
        check("b2b_valid_in_done", class_valid, 0);
        inputs = vec_c;
        inputs_ready = 1'b1;
        step();
        inputs_ready = 1'b0;
        check("b2b_first_valid", class_valid, 1);
        check("b2b_first_index", class_index, 2);
        check("b2b_restart_busy", busy, 1);
        wait_valid("b2b_second", 0, 10, 9, 1, 101);
        check("b2b_no_overrun", overrun, 0);

        // Reset mid-scan abandons the vector
        pulse(vec_a);
        step();
        step();
        step();
        step();
        reset = 1'b0;
        #1;
        check("mid_rst_index", class_index, 0);
        check("mid_rst_valid", class_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", state_dbg, IDLE);
`ifdef ARGMAX_CONFIDENCE_EN
        check("mid_rst_max_value", max_value, 0);
        check("mid_rst_margin", margin, 0);
`endif
        step();
        step();
        reset = 1'b1;
        valid_count = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (class_valid) valid_count++;
        end
        check("mid_rst_no_valid", valid_count, 0);

        // Next vector after reset; tie between 6 and 8 resolves to 6
        pulse(vec_d);
        wait_valid("d", 0, 10, 6, 11, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
